id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter CNT_W, default 16, width of the load-use stall counter.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 hold_i  in  1  global freeze from the memory system; all state holds.
REQ-005 flush_i  in  1  branch taken in ID; the instruction now in ID is discarded.
REQ-006 inst_i  in  32  IF/ID instruction; rs=[25:21], rt=[20:16], rd=[15:11].
REQ-007 RSdata_i, RTdata_i  in  32 each  register-file read data for rs and rt.
REQ-008 imm_i  in  32  sign-extended immediate.
REQ-009 RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i  in  1 each  decoded controls; ALUOp_i  in  2.
REQ-010 wb_RegWrite_i  in  1, wb_RDaddr_i  in  5, wb_RDdata_i  in  32  WB-stage write port, same as that driven into the register file.
REQ-011 Registered outputs: *_o copies of REQ-009 controls, RSdata_o, RTdata_o, imm_o (32), RSaddr_o, RTaddr_o, RDaddr_o (5), valid_o (1).
REQ-012 stall_o  out  1  combinational; freezes PC and IF/ID when high.
REQ-013 stall_cnt_o  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-014 Load-use hazard is defined as valid_o & MemRead_o & (RTaddr_o != 0) & (RTaddr_o == inst_i[25:21] | RTaddr_o == inst_i[20:16]).
REQ-015 stall_o equals the load-use hazard & ~flush_i & ~hold_i.
REQ-016 Edge priority: hold_i, then flush_i, then hazard, then normal load.
REQ-017 hold_i=1: every register, including stall_cnt_o, holds its value.
REQ-018 flush_i=1: load a bubble: all control outputs 0, valid_o 0, data and address fields loaded from inputs. The load is allowed to happen (stall_o 0).
REQ-019 Hazard: load a bubble as in REQ-018, and increment stall_cnt_o by 1.
REQ-020 Normal: load all fields from inputs with valid_o=1. RSaddr_o=rs, RTaddr_o=rt, RDaddr_o=rd.
REQ-021 WB bypass: on any data load, RSdata_o captures wb_RDdata_i when wb_RegWrite_i & wb_RDaddr_i!=0 & wb_RDaddr_i==rs. Otherwise it captures RSdata_i. RTdata_o follows the same rule for rt.
REQ-022 Register 0 is never bypassed; its captured data is RSdata_i/RTdata_i unchanged.
REQ-023 stall_cnt_o saturates at all-ones; it does not wrap.
REQ-024 Latency: one cycle from inputs to outputs. A load-use pair costs exactly one bubble.
REQ-025 A hazard is not re-raised on the cycle after a bubble, because valid_o=0.

Reset
REQ-026 While rst_n_i=0, all outputs are 0 independent of clk_i, and stall_o=0.
REQ-027 Deassertion takes effect at the first rising edge with rst_n_i=1.
REQ-028 Reset mid-stall clears the pending bubble; stall_cnt_o returns to 0.

Structure
REQ-029 A shared package holds the field-position constants (RS_MSB/LSB, RT_*, RD_*), ALUOp encodings, and the zero-register index.
REQ-030 Sub-module hazard_detect holds the combinational REQ-014/015 logic.
REQ-031 No other sub-modules exist. The pipeline register and counter are inline.

Verification
REQ-032 Reset: rst_n_i=0 mid-cycle with valid_o=1 -> all outputs 0 immediately, stall_cnt_o=0.
REQ-033 Load-use: EX holds lw with rt=5; ID holds add rs=5 -> stall_o=1; next edge gives valid_o=0, controls 0, stall_cnt_o=1; the following edge gives the add with valid_o=1.
REQ-034 Register-0 hazard: EX holds lw with rt=0; ID uses rs=0 -> stall_o=0, no bubble.
REQ-035 Bypass: wb writes 0xDEADBEEF to r7; ID rs=7 with RSdata_i=0x1 -> RSdata_o=0xDEADBEEF. With wb address 0, RSdata_o=0x1.
REQ-036 Priority: hazard, flush_i, and hold_i all asserted together -> no change. Releasing hold -> bubble loaded, stall_cnt_o unchanged.
REQ-037 Saturation: CNT_W=2 and 5 hazards -> stall_cnt_o stays at 3.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: instruction field
// positions, ALU operation encodings, the control bundle and the WB bypass rule.
package id_ex_stage_pkg;

   localparam int unsigned RS_MSB = 25;
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_MSB = 20;
   localparam int unsigned RT_LSB = 16;
   localparam int unsigned RD_MSB = 15;
   localparam int unsigned RD_LSB = 11;

   localparam logic [4:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_OR    = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_to_reg;
      logic    mem_read;
      logic    mem_write;
      logic    alu_src;
      logic    reg_dst;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // Register 0 is hardwired, so a WB write to it must never be forwarded.
   function automatic logic [31:0] wb_bypass(input logic        wb_we,
                                             input logic [4:0]  wb_addr,
                                             input logic [31:0] wb_data,
                                             input logic [4:0]  src_addr,
                                             input logic [31:0] rf_data);
      return (wb_we && (wb_addr != ZERO_REG) && (wb_addr == src_addr)) ? wb_data : rf_data;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic       ex_valid_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rt_addr_i,
   input  logic [4:0] id_rs_addr_i,
   input  logic [4:0] id_rt_addr_i,
   input  logic       flush_i,
   input  logic       hold_i,
   output logic       stall_o
);

   logic hazard;

   always_comb begin
      hazard = ex_valid_i && ex_mem_read_i && (ex_rt_addr_i != ZERO_REG) &&
               ((ex_rt_addr_i == id_rs_addr_i) || (ex_rt_addr_i == id_rt_addr_i));
      stall_o = hazard && !flush_i && !hold_i;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB-to-ID bypass
// and a saturating count of inserted bubbles.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             hold_i,
   input  logic             flush_i,
   input  logic [31:0]      inst_i,
   input  logic [31:0]      RSdata_i,
   input  logic [31:0]      RTdata_i,
   input  logic [31:0]      imm_i,
   input  logic             RegWrite_i,
   input  logic             MemtoReg_i,
   input  logic             MemRead_i,
   input  logic             MemWrite_i,
   input  logic             ALUSrc_i,
   input  logic             RegDst_i,
   input  logic [1:0]       ALUOp_i,
   input  logic             wb_RegWrite_i,
   input  logic [4:0]       wb_RDaddr_i,
   input  logic [31:0]      wb_RDdata_i,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             ALUSrc_o,
   output logic             RegDst_o,
   output logic [1:0]       ALUOp_o,
   output logic [31:0]      RSdata_o,
   output logic [31:0]      RTdata_o,
   output logic [31:0]      imm_o,
   output logic [4:0]       RSaddr_o,
   output logic [4:0]       RTaddr_o,
   output logic [4:0]       RDaddr_o,
   output logic             valid_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   ctrl_t             ctrl_q, ctrl_d, ctrl_in;
   logic              valid_q, valid_d;
   logic [31:0]       rs_data_q, rs_data_d;
   logic [31:0]       rt_data_q, rt_data_d;
   logic [31:0]       imm_q, imm_d;
   logic [4:0]        rs_addr_q, rs_addr_d;
   logic [4:0]        rt_addr_q, rt_addr_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [4:0]        id_rs, id_rt, id_rd;
   logic              stall;
   logic              load_bubble;
   logic              unused_inst_bits;

   assign id_rs = inst_i[RS_MSB:RS_LSB];
   assign id_rt = inst_i[RT_MSB:RT_LSB];
   assign id_rd = inst_i[RD_MSB:RD_LSB];
   assign unused_inst_bits = ^{inst_i[31:26], inst_i[10:0]};

   hazard_detect u_hazard_detect (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rt_addr_i  (rt_addr_q),
      .id_rs_addr_i  (id_rs),
      .id_rt_addr_i  (id_rt),
      .flush_i       (flush_i),
      .hold_i        (hold_i),
      .stall_o       (stall)
   );

   assign ctrl_in = '{reg_write:  RegWrite_i,
                      mem_to_reg: MemtoReg_i,
                      mem_read:   MemRead_i,
                      mem_write:  MemWrite_i,
                      alu_src:    ALUSrc_i,
                      reg_dst:    RegDst_i,
                      alu_op:     alu_op_e'(ALUOp_i)};

   // stall already excludes hold/flush, so it alone marks the hazard branch.
   assign load_bubble = flush_i || stall;

   always_comb begin
      ctrl_d      = ctrl_q;
      valid_d     = valid_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      imm_d       = imm_q;
      rs_addr_d   = rs_addr_q;
      rt_addr_d   = rt_addr_q;
      rd_addr_d   = rd_addr_q;
      stall_cnt_d = stall_cnt_q;
      if (!hold_i) begin
         valid_d   = !load_bubble;
         ctrl_d    = load_bubble ? CTRL_NOP : ctrl_in;
         rs_data_d = wb_bypass(wb_RegWrite_i, wb_RDaddr_i, wb_RDdata_i, id_rs, RSdata_i);
         rt_data_d = wb_bypass(wb_RegWrite_i, wb_RDaddr_i, wb_RDdata_i, id_rt, RTdata_i);
         imm_d     = imm_i;
         rs_addr_d = id_rs;
         rt_addr_d = id_rt;
         rd_addr_d = id_rd;
         if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctrl_q      <= CTRL_NOP;
         valid_q     <= 1'b0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rd_addr_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         rs_addr_q   <= rs_addr_d;
         rt_addr_q   <= rt_addr_d;
         rd_addr_q   <= rd_addr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign RegWrite_o  = ctrl_q.reg_write;
   assign MemtoReg_o  = ctrl_q.mem_to_reg;
   assign MemRead_o   = ctrl_q.mem_read;
   assign MemWrite_o  = ctrl_q.mem_write;
   assign ALUSrc_o    = ctrl_q.alu_src;
   assign RegDst_o    = ctrl_q.reg_dst;
   assign ALUOp_o     = ctrl_q.alu_op;
   assign RSdata_o    = rs_data_q;
   assign RTdata_o    = rt_data_q;
   assign imm_o       = imm_q;
   assign RSaddr_o    = rs_addr_q;
   assign RTaddr_o    = rt_addr_q;
   assign RDaddr_o    = rd_addr_q;
   assign valid_o     = valid_q;
   assign stall_o     = stall;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, hold, flush;
   logic [31:0] inst, rsd, rtd, imm, wbd;
   logic        rw, m2r, mr, mw, asrc, rdst, wbwe;
   logic [1:0]  aop;
   logic [4:0]  wba;

   logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o;
   logic [1:0]  ALUOp_o;
   logic [31:0] RSdata_o, RTdata_o, imm_o;
   logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
   logic        valid_o, stall_o;
   logic [15:0] stall_cnt_o;

   logic        s_rw, s_m2r, s_mr, s_mw, s_as, s_rd, s_valid, s_stall;
   logic [1:0]  s_aop;
   logic [31:0] s_rsd, s_rtd, s_imm;
   logic [4:0]  s_rsa, s_rta, s_rda;
   logic [1:0]  s_cnt;

   int checks = 0;
   int failures = 0;

   // behavioural model of the EX-side state
   logic        m_valid;
   logic [7:0]  m_ctrl;
   logic [31:0] m_rsd, m_rtd, m_imm;
   logic [4:0]  m_rsa, m_rta, m_rda;
   int          m_cnt, m_cnt_sat;
   int          saved_cnt;

   always #5 clk = ~clk;

   id_ex_stage u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold), .flush_i(flush), .inst_i(inst),
      .RSdata_i(rsd), .RTdata_i(rtd), .imm_i(imm),
      .RegWrite_i(rw), .MemtoReg_i(m2r), .MemRead_i(mr), .MemWrite_i(mw),
      .ALUSrc_i(asrc), .RegDst_i(rdst), .ALUOp_i(aop),
      .wb_RegWrite_i(wbwe), .wb_RDaddr_i(wba), .wb_RDdata_i(wbd),
      .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
      .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o),
      .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .imm_o(imm_o),
      .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o),
      .valid_o(valid_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   id_ex_stage #(.CNT_W(2)) u_dut_sat (
      .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold), .flush_i(flush), .inst_i(inst),
      .RSdata_i(rsd), .RTdata_i(rtd), .imm_i(imm),
      .RegWrite_i(rw), .MemtoReg_i(m2r), .MemRead_i(mr), .MemWrite_i(mw),
      .ALUSrc_i(asrc), .RegDst_i(rdst), .ALUOp_i(aop),
      .wb_RegWrite_i(wbwe), .wb_RDaddr_i(wba), .wb_RDdata_i(wbd),
      .RegWrite_o(s_rw), .MemtoReg_o(s_m2r), .MemRead_o(s_mr),
      .MemWrite_o(s_mw), .ALUSrc_o(s_as), .RegDst_o(s_rd), .ALUOp_o(s_aop),
      .RSdata_o(s_rsd), .RTdata_o(s_rtd), .imm_o(s_imm),
      .RSaddr_o(s_rsa), .RTaddr_o(s_rta), .RDaddr_o(s_rda),
      .valid_o(s_valid), .stall_o(s_stall), .stall_cnt_o(s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic exp_stall();
      logic [4:0] rs, rt;
      rs = inst[25:21];
      rt = inst[20:16];
      return m_valid && m_ctrl[5] && (m_rta != 0) && (m_rta == rs || m_rta == rt) && !flush && !hold;
   endfunction

   task automatic model_zero();
      m_valid = 0; m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      m_rsa = 0; m_rta = 0; m_rda = 0; m_cnt = 0; m_cnt_sat = 0;
   endtask

   task automatic model_step();
      logic       s;
      logic [4:0] rs, rt;
      s = exp_stall();
      if (hold) return;
      rs = inst[25:21];
      rt = inst[20:16];
      if (flush || s) begin
         m_valid = 0;
         m_ctrl  = 0;
      end else begin
         m_valid = 1;
         m_ctrl  = {rw, m2r, mr, mw, asrc, rdst, aop};
      end
      m_rsa = rs;
      m_rta = rt;
      m_rda = inst[15:11];
      m_imm = imm;
      m_rsd = (wbwe && wba != 0 && wba == rs) ? wbd : rsd;
      m_rtd = (wbwe && wba != 0 && wba == rt) ? wbd : rtd;
      if (s) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_sat < 3) m_cnt_sat++;
      end
   endtask

   task automatic check_state();
      chk("valid", valid_o, m_valid);
      chk("ctrl", {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o}, m_ctrl);
      chk("rs_data", RSdata_o, m_rsd);
      chk("rt_data", RTdata_o, m_rtd);
      chk("imm", imm_o, m_imm);
      chk("rs_addr", RSaddr_o, m_rsa);
      chk("rt_addr", RTaddr_o, m_rta);
      chk("rd_addr", RDaddr_o, m_rda);
      chk("stall", stall_o, exp_stall());
      chk("stall_cnt", stall_cnt_o, m_cnt);
      chk("sat_stall", s_stall, exp_stall());
      chk("sat_cnt", s_cnt, m_cnt_sat);
   endtask

   // entered and left at a falling edge with inputs already applied
   task automatic tick();
      #1;
      check_state();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      #1;
      check_state();
      @(posedge clk);
      model_step();
      #3;
      rst_n = 0;
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_ctrl", {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o}, 0);
      chk("rst_data", RSdata_o | RTdata_o | imm_o, 0);
      chk("rst_addr", {RSaddr_o, RTaddr_o, RDaddr_o}, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_cnt", stall_cnt_o, 0);
      chk("rst_sat_cnt", s_cnt, 0);
      model_zero();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic clear_in();
      hold = 0; flush = 0; inst = 0; rsd = 0; rtd = 0; imm = 0;
      rw = 0; m2r = 0; mr = 0; mw = 0; asrc = 0; rdst = 0; aop = 0;
      wbwe = 0; wba = 0; wbd = 0;
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1:       return 5'd5;
         2:       return 5'd7;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   task automatic drive_random();
      inst  = {6'($urandom), pick_reg(), pick_reg(), 5'($urandom), 11'($urandom)};
      rsd   = $urandom;  rtd = $urandom;  imm = $urandom;  wbd = $urandom;
      rw    = 1'($urandom); m2r = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom);
      asrc  = 1'($urandom); rdst = 1'($urandom); aop = 2'($urandom);
      wbwe  = 1'($urandom); wba = pick_reg();
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      clear_in();
      model_zero();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      chk("init_valid", valid_o, 0);
      chk("init_cnt", stall_cnt_o, 0);
      chk("init_stall", stall_o, 0);
      rst_n = 1;

      // load-use: lw rt=5 followed by use of r5
      clear_in(); inst = mk(1, 5, 9); mr = 1; rw = 1; m2r = 1;
      tick();
      inst = mk(5, 2, 3); mr = 0; m2r = 0;
      #1 chk("lu_stall", stall_o, 1);
      tick();
      chk("lu_bubble_valid", valid_o, 0);
      chk("lu_bubble_rw", RegWrite_o, 0);
      chk("lu_cnt", stall_cnt_o, 1);
      tick();
      chk("lu_add_valid", valid_o, 1);
      chk("lu_add_rs", RSaddr_o, 5);

      // load into r0 is not a hazard
      clear_in(); inst = mk(2, 0, 4); mr = 1;
      tick();
      inst = mk(0, 6, 1); mr = 0;
      #1 chk("r0_stall", stall_o, 0);
      tick();
      chk("r0_valid", valid_o, 1);

      // WB bypass, and no bypass of r0
      clear_in(); wbwe = 1; wba = 7; wbd = 32'hDEADBEEF; inst = mk(7, 3, 1); rsd = 32'h1;
      tick();
      chk("byp_hit", RSdata_o, 32'hDEADBEEF);
      wba = 0;
      tick();
      chk("byp_r0", RSdata_o, 32'h1);

      do_reset();

      // hold beats flush beats hazard
      clear_in(); inst = mk(1, 5, 9); mr = 1;
      tick();
      saved_cnt = m_cnt;
      inst = mk(5, 2, 3); mr = 0; flush = 1; hold = 1;
      #1 chk("prio_stall", stall_o, 0);
      tick();
      chk("prio_hold_valid", valid_o, 1);
      chk("prio_hold_rt", RTaddr_o, 5);
      chk("prio_hold_cnt", stall_cnt_o, saved_cnt);
      hold = 0;
      tick();
      chk("prio_flush_valid", valid_o, 0);
      chk("prio_flush_cnt", stall_cnt_o, saved_cnt);

      // counter saturation on the narrow instance
      do_reset();
      for (int i = 0; i < 5; i++) begin
         clear_in(); inst = mk(1, 5, 9); mr = 1;
         tick();
         inst = mk(5, 2, 3); mr = 0;
         tick();
         tick();
      end
      chk("sat_cnt3", s_cnt, 3);
      chk("wide_cnt5", stall_cnt_o, 5);

      for (int i = 0; i < 400; i++) begin
         drive_random();
         if ($urandom_range(0, 59) == 0) do_reset();
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
